// File: rtl/multicycle_data_path.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_data_path
// Description : Multi-cycle MIPS-subset datapath. Owns the PC, instruction
//               register, register file, a single shared ALU and the
//               sequencing FSM. Each instruction is split into fetch, decode,
//               execute, memory and writeback steps over one unified memory
//               port with a req/ack handshake (wait states allowed).
// Ports       : CLK, RST (sync, active low)
//               Mem_Addr/Mem_WData/Mem_Req/Mem_WE -> memory request side
//               Mem_Ack/Mem_RData                 <- memory response side
//               PC, Instr_Count, Illegal          -> status
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_data_path #(
    parameter int               WIDTH        = 32,
    parameter int               NUM_REGS     = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [WIDTH-1:0] Mem_Addr,
    output logic [WIDTH-1:0] Mem_WData,
    output logic             Mem_Req,
    output logic             Mem_WE,
    input  logic             Mem_Ack,
    input  logic [WIDTH-1:0] Mem_RData,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Instr_Count,
    output logic             Illegal
);

    localparam int c_IDX_W = $clog2(NUM_REGS);

    // FSM encoding
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXEC     = 4'd6;
    localparam logic [3:0] c_ALUWB    = 4'd7;
    localparam logic [3:0] c_ADDIEX   = 4'd8;
    localparam logic [3:0] c_ADDIWB   = 4'd9;
    localparam logic [3:0] c_BRANCH   = 4'd10;
    localparam logic [3:0] c_JUMP     = 4'd11;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_J     = 6'h02;

    // R-type functs
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [WIDTH-1:0] c_FOUR = WIDTH'(4);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [3:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_alu_out;
    logic [WIDTH-1:0] r_instr_count;
    logic             r_illegal;
    logic [WIDTH-1:0] r_regs [NUM_REGS];

    logic [5:0]         w_opcode;
    logic [5:0]         w_funct;
    logic [c_IDX_W-1:0] w_rs_idx;
    logic [c_IDX_W-1:0] w_rt_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [WIDTH-1:0]   w_sign_imm;
    logic [WIDTH-1:0]   w_jump_target;
    logic               w_funct_ok;
    logic [WIDTH-1:0]   w_alu_y;
    logic               w_mem_state;

    assign w_opcode      = r_ir[31:26];
    assign w_funct       = r_ir[5:0];
    // Register index is the low bits of each 5-bit field; upper bits alias.
    assign w_rs_idx      = r_ir[21 +: c_IDX_W];
    assign w_rt_idx      = r_ir[16 +: c_IDX_W];
    assign w_rd_idx      = r_ir[11 +: c_IDX_W];
    assign w_sign_imm    = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
    assign w_jump_target = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};

    // Shamt and the aliased upper index bits carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, r_ir[10:6], r_ir[25:21], r_ir[20:16], r_ir[15:11]};

    always_comb begin
        w_funct_ok = 1'b0;
        w_alu_y    = '0;
        case (w_funct)
            c_FN_ADD: begin w_funct_ok = 1'b1; w_alu_y = r_a + r_b; end
            c_FN_SUB: begin w_funct_ok = 1'b1; w_alu_y = r_a - r_b; end
            c_FN_AND: begin w_funct_ok = 1'b1; w_alu_y = r_a & r_b; end
            c_FN_OR:  begin w_funct_ok = 1'b1; w_alu_y = r_a | r_b; end
            c_FN_SLT: begin
                w_funct_ok = 1'b1;
                w_alu_y    = ($signed(r_a) < $signed(r_b)) ? c_ONE : '0;
            end
            default: ;
        endcase
    end

    // Memory port is a pure decode of the state register, so it stays stable
    // through wait cycles; reset masks the request immediately.
    assign w_mem_state = (r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                         (r_state == c_MEMWRITE);
    assign Mem_Req     = RST & w_mem_state;
    assign Mem_WE      = RST & (r_state == c_MEMWRITE);
    assign Mem_Addr    = (r_state == c_FETCH) ? r_pc : r_alu_out;
    assign Mem_WData   = r_b;

    assign PC          = r_pc;
    assign Instr_Count = r_instr_count;
    assign Illegal     = r_illegal;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= c_FETCH;
            r_pc          <= RESET_VECTOR;
            r_ir          <= '0;
            r_mdr         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_alu_out     <= '0;
            r_instr_count <= '0;
            r_illegal     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                c_FETCH: begin
                    if (Mem_Ack) begin
                        r_ir    <= Mem_RData[31:0];
                        r_pc    <= r_pc + c_FOUR;
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    r_a       <= r_regs[w_rs_idx];
                    r_b       <= r_regs[w_rt_idx];
                    // Speculative branch target from the already-incremented PC.
                    r_alu_out <= r_pc + (w_sign_imm << 2);
                    case (w_opcode)
                        c_OP_LW, c_OP_SW: r_state <= c_MEMADR;
                        c_OP_ADDI:        r_state <= c_ADDIEX;
                        c_OP_BEQ:         r_state <= c_BRANCH;
                        c_OP_J:           r_state <= c_JUMP;
                        c_OP_RTYPE: begin
                            if (w_funct_ok) begin
                                r_state <= c_EXEC;
                            end else begin
                                r_illegal <= 1'b1;
                                r_state   <= c_FETCH;
                            end
                        end
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= c_FETCH;
                        end
                    endcase
                end
                c_MEMADR: begin
                    r_alu_out <= r_a + w_sign_imm;
                    r_state   <= (w_opcode == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
                end
                c_MEMREAD: begin
                    if (Mem_Ack) begin
                        r_mdr   <= Mem_RData;
                        r_state <= c_MEMWB;
                    end
                end
                c_MEMWB: begin
                    if (w_rt_idx != '0) r_regs[w_rt_idx] <= r_mdr;
                    r_instr_count <= r_instr_count + c_ONE;
                    r_state       <= c_FETCH;
                end
                c_MEMWRITE: begin
                    if (Mem_Ack) begin
                        r_instr_count <= r_instr_count + c_ONE;
                        r_state       <= c_FETCH;
                    end
                end
                c_EXEC: begin
                    r_alu_out <= w_alu_y;
                    r_state   <= c_ALUWB;
                end
                c_ALUWB: begin
                    if (w_rd_idx != '0) r_regs[w_rd_idx] <= r_alu_out;
                    r_instr_count <= r_instr_count + c_ONE;
                    r_state       <= c_FETCH;
                end
                c_ADDIEX: begin
                    r_alu_out <= r_a + w_sign_imm;
                    r_state   <= c_ADDIWB;
                end
                c_ADDIWB: begin
                    if (w_rt_idx != '0) r_regs[w_rt_idx] <= r_alu_out;
                    r_instr_count <= r_instr_count + c_ONE;
                    r_state       <= c_FETCH;
                end
                c_BRANCH: begin
                    if (r_a == r_b) r_pc <= r_alu_out;
                    r_instr_count <= r_instr_count + c_ONE;
                    r_state       <= c_FETCH;
                end
                c_JUMP: begin
                    r_pc          <= w_jump_target;
                    r_instr_count <= r_instr_count + c_ONE;
                    r_state       <= c_FETCH;
                end
                default: r_state <= c_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
